// File: rtl/aes_lut_axil_slave.sv
// AXI4-Lite register slave in front of an AES core.
//
// Register map (word index = ADDR[5:2]):
//   0x00 CTRL     bit1 decrypt (rw), bit0 start (write 1 to start, reads 0)
//   0x04 STATUS   {30'b0, done, busy}; write 1 to bit1 clears done
//   0x08-0x14     KEY0-3 (KEY0 = aes_key[31:0])
//   0x18-0x24     DIN0-3 (DIN0 = aes_din[31:0])
//   0x28-0x34     DOUT0-3, read-only, captured on aes_done
//   0x38 SCRATCH  general rw
//   0x3C          unmapped, DECERR
//
// Ports:
//   ACLK, ARESETN        clock, async active-low reset
//   S_AXI_AW*/W*/B*      write address/data/response channels
//   S_AXI_AR*/R*         read address/data channels
//   aes_start            one-cycle start pulse to the core
//   aes_decrypt          direction select
//   aes_key, aes_din     key and input block, straight from registers
//   aes_dout, aes_done   result block and one-cycle completion pulse
//
// Optional build macro: AES_AXIL_WSTRB_EN -- when defined, WSTRB masks byte
// lanes of writable registers; otherwise every accepted write is full-word.
module aes_lut_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            aes_start,
    output logic                            aes_decrypt,
    output logic [127:0]                    aes_key,
    output logic [127:0]                    aes_din,
    input  logic [127:0]                    aes_dout,
    input  logic                            aes_done
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    localparam logic [3:0] AddrCtrl     = 4'h0;
    localparam logic [3:0] AddrStatus   = 4'h1;
    localparam logic [3:0] AddrKey0     = 4'h2;
    localparam logic [3:0] AddrDin0     = 4'h6;
    localparam logic [3:0] AddrDout0    = 4'hA;
    localparam logic [3:0] AddrScratch  = 4'hE;
    localparam logic [3:0] AddrUnmapped = 4'hF;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e state_q, state_d;
    logic   busy;

    // Channel state
    logic          ready_en_q;
    logic          aw_held_q, w_held_q;
    logic [3:0]    aw_idx_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic          bvalid_q, rvalid_q;
    logic [1:0]    bresp_q, rresp_q;
    logic [DW-1:0] rdata_q;

    // Register file
    logic [DW-1:0] key_q  [4];
    logic [DW-1:0] din_q  [4];
    logic [DW-1:0] dout_q [4];
    logic [DW-1:0] scratch_q;
    logic          decrypt_q, start_q, start_d, done_q, done_d;

    logic          commit, wr_en, core_busy, core_done, done_clr;
    logic [3:0]    wr_idx, rd_idx;
    logic [1:0]    wr_resp, rd_resp;
    logic [DW-1:0] rd_data;
    logic [SW-1:0] strb_eff;
    logic          ar_fire;

`ifdef AES_AXIL_WSTRB_EN
    assign strb_eff = w_strb_q;
`else
    assign strb_eff = '1;
`endif

    function automatic logic [DW-1:0] merge_strb(input logic [DW-1:0] old_val,
                                                  input logic [DW-1:0] new_val,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        for (int b = 0; b < SW; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_q)  state_d = StBusy;
            StBusy: if (aes_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q == StBusy);
        aes_start = start_q;
    end

    // Start pulse is in flight one cycle before the FSM reaches BUSY; treat
    // that cycle as busy so a second CTRL/KEY/DIN write cannot slip in.
    assign core_busy = busy | start_q;
    assign core_done = busy & aes_done;

    // ---------------- Write path ----------------
    assign S_AXI_AWREADY = ready_en_q & ~aw_held_q & ~bvalid_q;
    assign S_AXI_WREADY  = ready_en_q & ~w_held_q & ~bvalid_q;
    assign commit        = aw_held_q & w_held_q;
    assign wr_idx        = aw_idx_q;

    always_comb begin
        wr_resp = RespOkay;
        if (wr_idx == AddrUnmapped) begin
            wr_resp = RespDecErr;
        end else if (wr_idx >= AddrDout0 && wr_idx <= AddrDout0 + 4'd3) begin
            wr_resp = RespSlvErr;
        end else if (core_busy &&
                     (wr_idx == AddrCtrl ||
                      (wr_idx >= AddrKey0 && wr_idx <= AddrDin0 + 4'd3))) begin
            wr_resp = RespSlvErr;
        end
    end

    assign wr_en    = commit && (wr_resp == RespOkay);
    assign start_d  = wr_en && (wr_idx == AddrCtrl) && strb_eff[0] && w_data_q[0];
    assign done_clr = wr_en && (wr_idx == AddrStatus) && strb_eff[0] && w_data_q[1];

    // A completion in the same cycle as a clear wins.
    always_comb begin
        done_d = done_q;
        if (done_clr)  done_d = 1'b0;
        if (core_done) done_d = 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RespOkay;
        end else begin
            ready_en_q <= 1'b1;
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_held_q <= 1'b1;
                aw_idx_q  <= S_AXI_AWADDR[5:2];
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_held_q <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_resp;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
                bresp_q  <= RespOkay;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) begin
                key_q[i]  <= '0;
                din_q[i]  <= '0;
                dout_q[i] <= '0;
            end
            scratch_q <= '0;
            decrypt_q <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            start_q <= start_d;
            done_q  <= done_d;
            if (wr_en && wr_idx == AddrCtrl && strb_eff[0]) begin
                decrypt_q <= w_data_q[1];
            end
            for (int i = 0; i < 4; i++) begin
                if (wr_en && wr_idx == AddrKey0 + 4'(i)) begin
                    key_q[i] <= merge_strb(key_q[i], w_data_q, strb_eff);
                end
                if (wr_en && wr_idx == AddrDin0 + 4'(i)) begin
                    din_q[i] <= merge_strb(din_q[i], w_data_q, strb_eff);
                end
                if (core_done) begin
                    dout_q[i] <= aes_dout[32*i +: 32];
                end
            end
            if (wr_en && wr_idx == AddrScratch) begin
                scratch_q <= merge_strb(scratch_q, w_data_q, strb_eff);
            end
        end
    end

    assign aes_decrypt = decrypt_q;
    assign aes_key     = {key_q[3], key_q[2], key_q[1], key_q[0]};
    assign aes_din     = {din_q[3], din_q[2], din_q[1], din_q[0]};

    // ---------------- Read path ----------------
    assign S_AXI_ARREADY = ready_en_q & ~rvalid_q;
    assign ar_fire       = S_AXI_ARVALID & S_AXI_ARREADY;
    assign rd_idx        = S_AXI_ARADDR[5:2];

    // Registers are sampled before any same-cycle write lands.
    always_comb begin
        rd_data = '0;
        rd_resp = RespOkay;
        case (rd_idx)
            AddrCtrl:     rd_data = {{(DW-2){1'b0}}, decrypt_q, 1'b0};
            AddrStatus:   rd_data = {{(DW-2){1'b0}}, done_q, busy};
            AddrScratch:  rd_data = scratch_q;
            AddrUnmapped: rd_resp = RespDecErr;
            default: begin
                for (int i = 0; i < 4; i++) begin
                    if (rd_idx == AddrKey0 + 4'(i))  rd_data = key_q[i];
                    if (rd_idx == AddrDin0 + 4'(i))  rd_data = din_q[i];
                    if (rd_idx == AddrDout0 + 4'(i)) rd_data = dout_q[i];
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RespOkay;
        end else if (ar_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_resp;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         w_strb_q};

endmodule

// File: tb/tb_aes_lut_axil_slave.sv
module tb_aes_lut_axil_slave;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [5:0] A_CTRL    = 6'h00;
    localparam logic [5:0] A_STATUS  = 6'h04;
    localparam logic [5:0] A_KEY0    = 6'h08;
    localparam logic [5:0] A_KEY1    = 6'h0C;
    localparam logic [5:0] A_KEY2    = 6'h10;
    localparam logic [5:0] A_DOUT0   = 6'h28;
    localparam logic [5:0] A_DOUT3   = 6'h34;
    localparam logic [5:0] A_SCRATCH = 6'h38;
    localparam logic [5:0] A_UNMAP   = 6'h3C;

    logic         ACLK = 1'b0;
    logic         ARESETN;
    logic [5:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [5:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic         aes_start;
    logic         aes_decrypt;
    logic [127:0] aes_key;
    logic [127:0] aes_din;
    logic [127:0] aes_dout;
    logic         aes_done;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    // Behavioural model: word-indexed register image plus core status.
    logic [31:0] m_reg [16];
    bit          m_busy, m_done, m_dec;

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) if (aes_start) start_cnt++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    aes_lut_axil_slave dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .aes_start     (aes_start),
        .aes_decrypt   (aes_decrypt),
        .aes_key       (aes_key),
        .aes_din       (aes_din),
        .aes_dout      (aes_dout),
        .aes_done      (aes_done)
    );

    // ---------------- reference model ----------------
    function automatic logic [3:0] eff_strb(input logic [3:0] strb);
`ifdef AES_AXIL_WSTRB_EN
        return strb;
`else
        return 4'hF;
`endif
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_busy = 0;
        m_done = 0;
        m_dec  = 0;
    endtask

    function automatic logic [31:0] m_read(input int idx);
        if (idx == 0)  return {30'b0, m_dec, 1'b0};
        if (idx == 1)  return {30'b0, m_done, m_busy};
        if (idx == 15) return 32'h0;
        return m_reg[idx];
    endfunction

    function automatic logic [1:0] m_rresp(input int idx);
        return (idx == 15) ? DECERR : OKAY;
    endfunction

    task automatic m_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
        logic [3:0] s;
        s = eff_strb(strb);
        if (idx == 15)                                 resp = DECERR;
        else if (idx >= 10 && idx <= 13)               resp = SLVERR;
        else if (m_busy && (idx == 0 || (idx >= 2 && idx <= 9))) resp = SLVERR;
        else                                           resp = OKAY;
        if (resp != OKAY) return;
        if (idx == 0) begin
            if (s[0]) begin
                m_dec = data[1];
                if (data[0]) m_busy = 1;
            end
        end else if (idx == 1) begin
            if (s[0] && data[1]) m_done = 0;
        end else begin
            for (int b = 0; b < 4; b++) if (s[b]) m_reg[idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic m_core_done(input logic [127:0] v);
        if (!m_busy) return;
        for (int i = 0; i < 4; i++) m_reg[10 + i] = v[32*i +: 32];
        m_done = 1;
        m_busy = 0;
    endtask

    // ---------------- bus helpers ----------------
    task automatic bus_fail(input string what);
        checks++;
        errors++;
        $display("FAIL %s: handshake timed out", what);
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_d, w_d, aw_hs, w_hs;
        int n;
        aw_d = 0; w_d = 0; n = 0;
        @(negedge ACLK);
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1;
        while (!(aw_d && w_d) && n < 20) begin
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            @(negedge ACLK);
            n++;
            if (aw_hs) begin aw_d = 1; S_AXI_AWVALID = 0; end
            if (w_hs)  begin w_d = 1;  S_AXI_WVALID = 0;  end
        end
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        if (!(aw_d && w_d)) bus_fail("write_addr_data");
        S_AXI_BREADY = 1;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
        resp = 2'bxx;
        if (S_AXI_BVALID) resp = S_AXI_BRESP;
        else bus_fail("write_resp");
        @(negedge ACLK);
        S_AXI_BREADY = 0;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        n = 0;
        @(negedge ACLK);
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1;
        while (!S_AXI_ARREADY && n < 20) begin @(negedge ACLK); n++; end
        if (!S_AXI_ARREADY) bus_fail("read_addr");
        @(negedge ACLK);
        S_AXI_ARVALID = 0;
        S_AXI_RREADY = 1;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
        data = 32'hxxxxxxxx; resp = 2'bxx;
        if (S_AXI_RVALID) begin data = S_AXI_RDATA; resp = S_AXI_RRESP; end
        else bus_fail("read_data");
        @(negedge ACLK);
        S_AXI_RREADY = 0;
    endtask

    task automatic pulse_done(input logic [127:0] v);
        @(negedge ACLK);
        aes_dout = v; aes_done = 1;
        @(negedge ACLK);
        aes_done = 0;
        m_core_done(v);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        ARESETN = 0;
        m_reset();
        repeat (3) @(negedge ACLK);
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake: got %b expected 00000",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
        end
        checks++;
        if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, aes_start, aes_decrypt, aes_key, aes_din} !== '0)
        begin
            errors++;
            $display("FAIL reset_outputs: bresp %b rresp %b rdata %h start %b dec %b",
                     S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, aes_start, aes_decrypt);
        end
        ARESETN = 1;
        repeat (2) @(negedge ACLK);
        for (int i = 0; i < 16; i++) begin
            axi_read(6'(i * 4), d, r);
            checks++;
            if (d !== m_read(i) || r !== m_rresp(i)) begin
                errors++;
                $display("FAIL reset_reg[%0d]: got %h/%b expected %h/%b", i, d, r, m_read(i),
                         m_rresp(i));
            end
        end
    endtask

    task automatic test_basic_rw();
        logic [31:0] d;
        logic [1:0]  r, er;
        axi_write(A_KEY0, 32'h11223344, 4'hF, r);
        m_write(2, 32'h11223344, 4'hF, er);
        axi_write(A_SCRATCH, 32'hA5A5A5A5, 4'hF, r);
        m_write(14, 32'hA5A5A5A5, 4'hF, er);
        axi_read(A_KEY0, d, r);
        checks++;
        if (d !== 32'h11223344 || r !== OKAY) begin
            errors++;
            $display("FAIL key0_readback: got %h/%b expected 11223344/00", d, r);
        end
        axi_read(A_SCRATCH, d, r);
        checks++;
        if (d !== 32'hA5A5A5A5 || r !== OKAY) begin
            errors++;
            $display("FAIL scratch_readback: got %h/%b expected a5a5a5a5/00", d, r);
        end
        checks++;
        if (aes_key[31:0] !== 32'h11223344) begin
            errors++;
            $display("FAIL aes_key_port: got %h expected 11223344", aes_key[31:0]);
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        logic [1:0]  r, er;
        bit wready_hi, b_early, b_drop, b_extra;
        int n, bcnt;
        wready_hi = 0; b_early = 0; b_drop = 0; b_extra = 0; n = 0;
        @(negedge ACLK);
        S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
        while (!S_AXI_WREADY && n < 20) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        S_AXI_WVALID = 0;
        // W is now held; two more idle cycles make AW arrive three cycles later
        for (int i = 0; i < 2; i++) begin
            if (S_AXI_WREADY) wready_hi = 1;
            if (S_AXI_BVALID) b_early = 1;
            @(negedge ACLK);
        end
        checks++;
        if (wready_hi || b_early) begin
            errors++;
            $display("FAIL w_hold: got wready %b bvalid %b expected 0 0", wready_hi, b_early);
        end
        S_AXI_AWADDR = A_KEY2; S_AXI_AWVALID = 1;
        n = 0;
        while (!S_AXI_AWREADY && n < 20) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        S_AXI_AWVALID = 0;
        m_write(4, 32'hCAFEF00D, 4'hF, er);
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
        // BREADY held low: response must stay put
        repeat (3) begin
            if (!S_AXI_BVALID || S_AXI_BRESP !== OKAY) b_drop = 1;
            @(negedge ACLK);
        end
        checks++;
        if (b_drop) begin
            errors++;
            $display("FAIL b_hold: got bvalid %b bresp %b expected 1 00", S_AXI_BVALID, S_AXI_BRESP);
        end
        S_AXI_BREADY = 1;
        @(negedge ACLK);
        S_AXI_BREADY = 0;
        bcnt = 0;
        repeat (5) begin
            if (S_AXI_BVALID) b_extra = 1;
            @(negedge ACLK);
        end
        checks++;
        if (b_extra) begin
            errors++;
            $display("FAIL single_b: got extra bvalid expected none");
        end
        axi_read(A_KEY2, d, r);
        checks++;
        if (d !== m_read(4) || aes_key[95:64] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL key2_commit: got %h port %h expected cafef00d", d, aes_key[95:64]);
        end
    endtask

    task automatic test_ctrl_start();
        logic [31:0] d;
        logic [1:0]  r, er;
        int c0;
        c0 = start_cnt;
        axi_write(A_CTRL, 32'h3, 4'hF, r);
        m_write(0, 32'h3, 4'hF, er);
        repeat (4) @(negedge ACLK);
        checks++;
        if (start_cnt - c0 != 1 || aes_decrypt !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: got %0d cycles dec %b expected 1 cycle dec 1",
                     start_cnt - c0, aes_decrypt);
        end
        axi_read(A_STATUS, d, r);
        checks++;
        if (d !== 32'h1 || d !== m_read(1)) begin
            errors++;
            $display("FAIL status_busy: got %h expected 00000001", d);
        end
        axi_write(A_KEY1, 32'hDEADBEEF, 4'hF, r);
        m_write(3, 32'hDEADBEEF, 4'hF, er);
        checks++;
        if (r !== SLVERR || r !== er) begin
            errors++;
            $display("FAIL key1_busy_resp: got %b expected 10", r);
        end
        axi_read(A_KEY1, d, r);
        checks++;
        if (d !== 32'h0 || d !== m_read(3)) begin
            errors++;
            $display("FAIL key1_unchanged: got %h expected 00000000", d);
        end
    endtask

    task automatic test_done();
        logic [31:0] d;
        logic [1:0]  r, er;
        pulse_done(128'h000102030405060708090A0B0C0D0E0F);
        axi_read(A_DOUT0, d, r);
        checks++;
        if (d !== 32'h0C0D0E0F) begin
            errors++;
            $display("FAIL dout0: got %h expected 0c0d0e0f", d);
        end
        axi_read(A_DOUT3, d, r);
        checks++;
        if (d !== 32'h00010203 || d !== m_read(13)) begin
            errors++;
            $display("FAIL dout3: got %h expected 00010203", d);
        end
        axi_read(A_STATUS, d, r);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL status_done: got %h expected 00000002", d);
        end
        axi_write(A_STATUS, 32'h2, 4'hF, r);
        m_write(1, 32'h2, 4'hF, er);
        axi_read(A_STATUS, d, r);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL status_clear: got %h expected 00000000", d);
        end
        // aes_done while idle must be ignored
        pulse_done({4{32'hFFFF0000}});
        axi_read(A_DOUT0, d, r);
        checks++;
        if (d !== 32'h0C0D0E0F || m_read(1) !== 32'h0) begin
            errors++;
            $display("FAIL idle_done_ignored: got %h expected 0c0d0e0f", d);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic [1:0]  r, er;
        axi_read(A_UNMAP, d, r);
        checks++;
        if (d !== 32'h0 || r !== DECERR) begin
            errors++;
            $display("FAIL unmapped_read: got %h/%b expected 00000000/11", d, r);
        end
        axi_write(A_UNMAP, 32'h12345678, 4'hF, r);
        m_write(15, 32'h12345678, 4'hF, er);
        checks++;
        if (r !== DECERR) begin
            errors++;
            $display("FAIL unmapped_write: got %b expected 11", r);
        end
        axi_write(A_DOUT0, 32'h12345678, 4'hF, r);
        m_write(10, 32'h12345678, 4'hF, er);
        checks++;
        if (r !== SLVERR) begin
            errors++;
            $display("FAIL dout_write: got %b expected 10", r);
        end
        axi_read(A_DOUT0, d, r);
        checks++;
        if (d !== 32'h0C0D0E0F) begin
            errors++;
            $display("FAIL dout_unchanged: got %h expected 0c0d0e0f", d);
        end
    endtask

    task automatic test_wstrb();
        logic [31:0] d, exp;
        logic [1:0]  r, er;
        axi_write(A_SCRATCH, 32'h0, 4'hF, r);
        m_write(14, 32'h0, 4'hF, er);
        axi_write(A_SCRATCH, 32'hFFFFFFFF, 4'h1, r);
        m_write(14, 32'hFFFFFFFF, 4'h1, er);
`ifdef AES_AXIL_WSTRB_EN
        exp = 32'h000000FF;
`else
        exp = 32'hFFFFFFFF;
`endif
        axi_read(A_SCRATCH, d, r);
        checks++;
        if (d !== exp) begin
            errors++;
            $display("FAIL wstrb_scratch: got %h expected %h", d, exp);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, data;
        logic [1:0]  r, er;
        int idx, op;
        for (int k = 0; k < 60; k++) begin
            op   = $urandom_range(0, 9);
            idx  = $urandom_range(0, 15);
            data = $urandom;
            if (op < 5) begin
                logic [3:0] strb;
                strb = 4'($urandom_range(0, 15));
                axi_write(6'(idx * 4), data, strb, r);
                m_write(idx, data, strb, er);
                checks++;
                if (r !== er) begin
                    errors++;
                    $display("FAIL rand_wresp[%0d] idx %0d: got %b expected %b", k, idx, r, er);
                end
            end else if (op < 9) begin
                axi_read(6'(idx * 4), d, r);
                checks++;
                if (d !== m_read(idx) || r !== m_rresp(idx)) begin
                    errors++;
                    $display("FAIL rand_read[%0d] idx %0d: got %h/%b expected %h/%b", k, idx, d, r,
                             m_read(idx), m_rresp(idx));
                end
            end else begin
                pulse_done({$urandom, $urandom, $urandom, $urandom});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r, er;
        bit seen_b, seen_r;
        int n;
        seen_b = 0; seen_r = 0; n = 0;
        @(negedge ACLK);
        S_AXI_AWADDR = A_SCRATCH; S_AXI_AWVALID = 1;
        while (!S_AXI_AWREADY && n < 20) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        S_AXI_AWVALID = 0;
        S_AXI_ARADDR = A_KEY0; S_AXI_ARVALID = 1;
        @(negedge ACLK);
        S_AXI_ARVALID = 0;
        ARESETN = 0;
        m_reset();
        repeat (2) @(negedge ACLK);
        ARESETN = 1;
        repeat (6) begin
            if (S_AXI_BVALID) seen_b = 1;
            if (S_AXI_RVALID) seen_r = 1;
            @(negedge ACLK);
        end
        checks++;
        if (seen_b || seen_r) begin
            errors++;
            $display("FAIL reset_drop_resp: got bvalid %b rvalid %b expected 0 0", seen_b, seen_r);
        end
        // W alone must not pair with the AW dropped by reset
        S_AXI_WDATA = 32'h5A5A1234; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
        n = 0;
        while (!S_AXI_WREADY && n < 20) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        S_AXI_WVALID = 0;
        seen_b = 0;
        repeat (4) begin
            if (S_AXI_BVALID) seen_b = 1;
            @(negedge ACLK);
        end
        checks++;
        if (seen_b) begin
            errors++;
            $display("FAIL reset_drop_aw: got bvalid 1 expected 0");
        end
        S_AXI_AWADDR = A_SCRATCH; S_AXI_AWVALID = 1;
        n = 0;
        while (!S_AXI_AWREADY && n < 20) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        S_AXI_AWVALID = 0;
        m_write(14, 32'h5A5A1234, 4'hF, er);
        S_AXI_BREADY = 1;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
        checks++;
        if (!S_AXI_BVALID || S_AXI_BRESP !== er) begin
            errors++;
            $display("FAIL post_reset_write: got bvalid %b bresp %b expected 1 %b", S_AXI_BVALID,
                     S_AXI_BRESP, er);
        end
        @(negedge ACLK);
        S_AXI_BREADY = 0;
        axi_read(A_SCRATCH, d, r);
        checks++;
        if (d !== m_read(14)) begin
            errors++;
            $display("FAIL post_reset_scratch: got %h expected %h", d, m_read(14));
        end
    endtask

    initial begin
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 0;
        S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 0;
        S_AXI_BREADY = 0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 0;
        S_AXI_RREADY = 0;
        aes_dout = '0; aes_done = 0;
        test_reset();
        test_basic_rw();
        test_w_before_aw();
        test_ctrl_start();
        test_done();
        test_errors();
        test_wstrb();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
